cpu_ctrl_seq: RTL

Multi-cycle control sequencer for the 8-bit accumulator CPU inside `tt_um_8bit_cpu`. It fetches each instruction from the shared program/data memory through a req/ack handshake, decodes the 4-bit opcode held in the IR, and issues one-cycle strobes to the PC, MAR, IR, accumulator, ALU flags and output register. It supports free-run and single-step modes from the pin inputs. A wait-state watchdog traps a hung memory in a sticky fault state.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/cpu_ctrl_watchdog.sv | 20 ++
 rtl/cpu_ctrl_seq.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, sequencer state encoding and accumulator source select for the 8-bit CPU
package cpu_pkg;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_FWAIT  = 3'd1,
        S_DECODE = 3'd2,
        S_MWAIT  = 3'd3,
        S_HALT   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam logic [1:0] ASEL_ALU = 2'b00;
    localparam logic [1:0] ASEL_MEM = 2'b01;
    localparam logic [1:0] ASEL_IMM = 2'b10;
    function automatic logic is_mem_op(input logic [3:0] op);
        return op inside {OP_LDA, OP_ADD, OP_SUB, OP_STA};
    endfunction
    function automatic logic is_bad_op(input logic [3:0] op);
        return op inside {[4'h9:4'hD]};
    endfunction
endpackage

// File: rtl/cpu_ctrl_watchdog.sv
// cpu_ctrl_watchdog: counts unacknowledged memory wait cycles and flags a timeout at MAX_WAIT
module cpu_ctrl_watchdog #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic busy,
    input  logic ack,
    output logic timeout
);
    logic [WAIT_W-1:0] cnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (busy && !ack) cnt <= cnt + 1'b1;
    // an ack in the timeout cycle takes priority
    assign timeout = busy && !ack && cnt == WAIT_W'(MAX_WAIT);
endmodule

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: multi-cycle fetch/decode/execute sequencer with single-step and memory watchdog
module cpu_ctrl_seq
    import cpu_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step_mode,
    input  logic       step,
    input  logic [3:0] opcode,
    input  logic       flag_c,
    input  logic       flag_z,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mar_load,
    output logic       mar_sel,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       a_load,
    output logic [1:0] a_sel,
    output logic       alu_sub,
    output logic       flags_load,
    output logic       out_load,
    output logic       retire,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state
);
    state_t state_q, state_d;
    logic step_q, go, busy, clr, timeout;
    assign go = run && (!step_mode || (step && !step_q));
    assign busy = state_q == S_FWAIT || state_q == S_MWAIT;
    assign clr = (state_q == S_FETCH && go) || (state_q == S_DECODE && is_mem_op(opcode));
    cpu_ctrl_watchdog #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_wd (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy), .ack(mem_ack), .timeout(timeout)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_FETCH;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step;
        end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = go ? S_FWAIT : S_FETCH;
            S_FWAIT:  state_d = mem_ack ? S_DECODE : timeout ? S_FAULT : S_FWAIT;
            S_DECODE: state_d = is_mem_op(opcode) ? S_MWAIT : opcode == OP_HLT ? S_HALT :
                                is_bad_op(opcode) ? S_FAULT : S_FETCH;
            S_MWAIT:  state_d = mem_ack ? S_FETCH : timeout ? S_FAULT : S_MWAIT;
            S_HALT, S_FAULT: state_d = state_q;
            default:  state_d = S_FETCH;
        endcase
    end
    // all strobes are held low during reset, including the FETCH mar_load
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mar_load   = 1'b0;
        mar_sel    = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        a_load     = 1'b0;
        a_sel      = ASEL_ALU;
        alu_sub    = 1'b0;
        flags_load = 1'b0;
        out_load   = 1'b0;
        retire     = 1'b0;
        if (!rst)
            case (state_q)
                S_FETCH: mar_load = go;
                S_FWAIT: begin
                    mem_req = !timeout;
                    ir_load = mem_ack;
                    pc_inc  = mem_ack;
                end
                S_DECODE: begin
                    mar_load = is_mem_op(opcode);
                    mar_sel  = is_mem_op(opcode);
                    a_load   = opcode == OP_LDI;
                    a_sel    = opcode == OP_LDI ? ASEL_IMM : ASEL_ALU;
                    pc_load  = opcode == OP_JMP || (opcode == OP_JC && flag_c) || (opcode == OP_JZ && flag_z);
                    out_load = opcode == OP_OUT;
                    retire   = !is_mem_op(opcode) && !is_bad_op(opcode);
                end
                S_MWAIT: begin
                    mem_req    = !timeout;
                    mem_we     = !timeout && opcode == OP_STA;
                    a_load     = mem_ack && opcode inside {OP_LDA, OP_ADD, OP_SUB};
                    a_sel      = mem_ack && opcode == OP_LDA ? ASEL_MEM : ASEL_ALU;
                    flags_load = mem_ack && opcode inside {OP_ADD, OP_SUB};
                    alu_sub    = mem_ack && opcode == OP_SUB;
                    retire     = mem_ack;
                end
                default: ;
            endcase
    end
    assign halted = state_q == S_HALT;
    assign fault  = state_q == S_FAULT;
    assign state  = state_q;
endmodule
